pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h00000020, exception handler entry address.
REQ-002 SHALL have parameter MEM_STALL_LIMIT, default 255, maximum consecutive MEM-stall cycles before timeout.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset (`RstEnable).
REQ-005 stallreq_id_i  input  1  ID-stage stall request (load-use hazard).
REQ-006 stallreq_ex_i  input  1  EX-stage stall request (multi-cycle mul/div).
REQ-007 stallreq_mem_i  input  1  MEM-stage stall request (data bus not ready).
REQ-008 excepttype_i  input  32  exception code from MEM stage; zero means none, 32'h0000000e means ERET.
REQ-009 cp0_epc_i  input  32  CP0 EPC, return address for ERET.
REQ-010 stall_o  output  6  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-011 flush_o  output  1  clears all pipeline registers; PC loads new_pc_o at next edge.
REQ-012 new_pc_o  output  32  redirect target, valid while flush_o=1.
REQ-013 bus_timeout_o  output  1  sticky flag: MEM stall exceeded limit.

Function
REQ-014 SHALL implement FSM states RUN and FLUSH_HOLD.
REQ-015 In RUN with excepttype_i!=0: flush_o=1, stall_o=6'b000000 in the same cycle (combinational); next state FLUSH_HOLD.
REQ-016 new_pc_o SHALL be cp0_epc_i when excepttype_i==32'h0000000e, else EXC_VECTOR; 32'h0 when flush_o=0.
REQ-017 In FLUSH_HOLD: flush_o=0, excepttype_i ignored for exactly one cycle, stall requests honoured; next state RUN.
REQ-018 Stall encoding with no flush, highest-priority request wins: mem -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, none -> 6'b000000.
REQ-019 Exception in RUN SHALL override all stall requests that cycle.
REQ-020 Stall counter SHALL increment each cycle stallreq_mem_i=1, clear when stallreq_mem_i=0 or flush_o=1, saturate at MEM_STALL_LIMIT.
REQ-021 bus_timeout_o SHALL set on the edge where the counter reaches MEM_STALL_LIMIT and remain set until rst.
REQ-022 stall_o and flush_o SHALL NOT be asserted simultaneously.

Reset
REQ-023 On rst=1 at posedge: state=RUN, stall counter=0, bus_timeout_o=0, perf counters=0.
REQ-024 While rst=1: stall_o=6'b000000, flush_o=0, new_pc_o=32'h0 regardless of inputs.
REQ-025 Reset mid-FLUSH_HOLD SHALL return to RUN; no pending flush is replayed.

Configuration
REQ-026 Macro PIPE_PERF_CNT_EN SHALL, when defined, add outputs stall_cycles_o[31:0] (cycles with stall_o!=0) and flush_count_o[31:0] (cycles with flush_o=1), both wrapping modulo 2^32.
REQ-027 Without PIPE_PERF_CNT_EN these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-028 Stall encodings, ERET code 32'h0000000e, FSM state encodings and ZeroWord SHALL live in the shared defines header.
REQ-029 Stall-timeout counter plus sticky flag SHALL be a sub-module stall_watchdog; everything else inline.

Verification
REQ-030 stallreq_id_i=1 only -> stall_o=6'b000111; add stallreq_mem_i=1 -> 6'b011111 same cycle.
REQ-031 RUN, excepttype_i=32'h00000008 -> flush_o=1, new_pc_o=32'h00000020, stall_o=0; next cycle flush_o=0 even if excepttype_i unchanged.
REQ-032 excepttype_i=32'h0000000e, cp0_epc_i=32'h00400100 -> new_pc_o=32'h00400100, flush_o=1 one cycle.
REQ-033 Exception and stallreq_ex_i=1 same cycle -> flush_o=1, stall_o=0; FLUSH_HOLD cycle with stallreq_ex_i=1 -> stall_o=6'b001111.
REQ-034 stallreq_mem_i held 255 cycles (MEM_STALL_LIMIT=255) -> bus_timeout_o=1 after 255th edge, stays 1 after release until rst.
REQ-035 rst asserted during FLUSH_HOLD -> next cycle state RUN, all outputs zero; with PIPE_PERF_CNT_EN counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall encodings, the ERET
// exception code, FSM state encoding and the all-zero word.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN        = 1'b0,
        ST_FLUSH_HOLD = 1'b1
    } pipe_state_e;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] ERET_CODE = 32'h0000_000e;

    // Hold masks: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    // The deepest stalling stage wins: it must also freeze everything upstream.
    function automatic logic [5:0] stall_encode(input logic id_req,
                                                input logic ex_req,
                                                input logic mem_req);
        logic [5:0] mask;
        mask = STALL_NONE;
        if (mem_req)     mask = STALL_MEM;
        else if (ex_req) mask = STALL_EX;
        else if (id_req) mask = STALL_ID;
        return mask;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// stall_watchdog: counts consecutive MEM-stall cycles, saturating at
// MEM_STALL_LIMIT, and raises a sticky timeout flag cleared only by reset.
module stall_watchdog #(
    parameter int MEM_STALL_LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_mem_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam int CW = (MEM_STALL_LIMIT < 2) ? 1 : $clog2(MEM_STALL_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(MEM_STALL_LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // Next count: restart on any break in the stall run or on a flush; hold at the limit.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (clear_i || !stall_mem_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT_C) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == LIMIT_C && stall_mem_i && !clear_i) begin
            timeout_d = 1'b1;
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller. Exceptions from MEM flush the
// pipe and redirect the PC; otherwise the deepest stall request freezes the
// pipe. Optional macro PIPE_PERF_CNT_EN adds stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR      = 32'h0000_0020,
    parameter int          MEM_STALL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        bus_timeout_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
`endif
);

    pipe_state_e state_q, state_d;

    // Flush/stall decode: an exception taken in RUN overrides every stall request,
    // and the cycle after a flush ignores the still-visible exception code.
    always_comb begin
        state_d  = state_q;
        flush_o  = 1'b0;
        stall_o  = STALL_NONE;
        new_pc_o = ZERO_WORD;
        if (!rst) begin
            if (state_q == ST_RUN && excepttype_i != ZERO_WORD) begin
                flush_o  = 1'b1;
                new_pc_o = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                state_d  = ST_FLUSH_HOLD;
            end else begin
                stall_o = stall_encode(stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
                state_d = ST_RUN;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    stall_watchdog #(
        .MEM_STALL_LIMIT (MEM_STALL_LIMIT)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .stall_mem_i (stallreq_mem_i),
        .clear_i     (flush_o),
        .timeout_o   (bus_timeout_o)
    );

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Performance counter next-state; both wrap naturally at 2^32.
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, (stall_o != STALL_NONE)};
        flush_count_d  = flush_count_q + {31'd0, flush_o};
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: random and directed stimulus, reference model
// expressed as consecutive-stall run length and a "just flushed" flag,
// expected responses queued and checked by an independent monitor.
module tb_pipe_ctrl;

    localparam int LIMIT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_req = 1'b0, ex_req = 1'b0, mem_req = 1'b0;
    logic [31:0] exc = 32'h0, epc = 32'h0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(
        .EXC_VECTOR      (32'h0000_0020),
        .MEM_STALL_LIMIT (LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id_i  (id_req),
        .stallreq_ex_i  (ex_req),
        .stallreq_mem_i (mem_req),
        .excepttype_i   (exc),
        .cp0_epc_i      (epc),
        .stall_o        (stall),
        .flush_o        (flush),
        .new_pc_o       (new_pc),
        .bus_timeout_o  (timeout)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles_o (stall_cycles),
        .flush_count_o  (flush_count)
`endif
    );

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        timeout;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   drv_done = 1'b0;

    // Reference model state
    bit          m_just_flushed = 1'b0;
    int          m_mem_run      = 0;
    bit          m_timeout      = 1'b0;
    logic [31:0] m_sc           = 32'h0;
    logic [31:0] m_fc           = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus: apply inputs, queue the expected outputs,
    // then advance the model across the coming edge.
    task automatic cyc(input bit r, input bit i, input bit e, input bit m,
                       input logic [31:0] x, input logic [31:0] pc_in);
        exp_t ex;
        @(posedge clk);
        #1;
        rst = r; id_req = i; ex_req = e; mem_req = m; exc = x; epc = pc_in;
        ex = '0;
        ex.timeout = m_timeout;
        ex.sc = m_sc;
        ex.fc = m_fc;
        if (!r) begin
            ex.flush = !m_just_flushed && (x != 0);
            if (ex.flush) ex.pc = (x == 32'he) ? pc_in : 32'h20;
            else if (m)   ex.stall = 6'b011111;
            else if (e)   ex.stall = 6'b001111;
            else if (i)   ex.stall = 6'b000111;
        end
        exp_q.push_back(ex);
        if (r) begin
            m_just_flushed = 1'b0;
            m_mem_run = 0;
            m_timeout = 1'b0;
            m_sc = 0;
            m_fc = 0;
        end else begin
            m_just_flushed = ex.flush;
            m_mem_run = (m && !ex.flush) ? m_mem_run + 1 : 0;
            if (m_mem_run >= LIMIT) m_timeout = 1'b1;
            if (ex.stall != 0) m_sc = m_sc + 1;
            if (ex.flush)      m_fc = m_fc + 1;
        end
    endtask

    // Monitor: mid-cycle, compare every presented output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall_o", {26'd0, stall}, {26'd0, e.stall});
                check("flush_o", {31'd0, flush}, {31'd0, e.flush});
                check("new_pc_o", new_pc, e.pc);
                check("bus_timeout_o", {31'd0, timeout}, {31'd0, e.timeout});
`ifdef PIPE_PERF_CNT_EN
                check("stall_cycles_o", stall_cycles, e.sc);
                check("flush_count_o", flush_count, e.fc);
`endif
            end
        end
    end

    // Driver: directed scenarios then randomized traffic.
    initial begin
        logic [31:0] xr;
        int r;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 32'h8, 32'h1234);       // outputs held low during reset
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);                  // id only
        cyc(0, 1, 0, 1, 0, 0);                  // id + mem
        cyc(0, 1, 1, 0, 0, 0);                  // ex beats id
        cyc(0, 0, 0, 0, 32'h8, 0);              // exception
        cyc(0, 0, 0, 0, 32'h8, 0);              // ignored in hold
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 32'he, 32'h0040_0100);  // ERET
        cyc(0, 0, 0, 0, 0, 32'h0040_0100);
        cyc(0, 0, 1, 0, 32'h8, 0);              // exception overrides ex stall
        cyc(0, 0, 1, 0, 32'h8, 0);              // hold cycle honours ex stall
        cyc(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < LIMIT + 3; k++) cyc(0, 0, 0, 1, 0, 0);  // timeout
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 0);          // sticky
        cyc(0, 0, 0, 0, 32'h10, 0);
        cyc(1, 0, 0, 0, 32'h10, 0);             // reset during hold
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 32'h10, 0);             // back in RUN: flushes again
        for (int k = 0; k < 2000; k++) begin
            r = $urandom_range(0, 99);
            xr = 32'h0;
            if (r < 8)       xr = 32'h8;
            else if (r < 13) xr = 32'he;
            else if (r < 16) xr = $urandom;
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), xr, $urandom);
        end
        for (int k = 0; k < 300; k++) cyc(0, 0, 0, ($urandom_range(0, 49) != 0), 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        drv_done = 1'b1;
    end

    // Completion: bounded wait for the driver, then confirm the scoreboard drained.
    initial begin
        int budget;
        budget = 0;
        while (!drv_done && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        check("driver_done", {31'd0, drv_done}, 32'd1);
        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
